tdm_signal_multiplexer: RTL
===========================

# tdm_signal_multiplexer

Time-division multiplexer that merges NUM_CH independent input channels into one slotted output stream, tagging each word with its channel index. It is the transmit-side counterpart of the digital signal demultiplexer, which fans out to channels by `sel`: `data_out` and `sel_out` of this block drive `data_in` and `sel` of the demultiplexer directly. Each channel has a one-entry holding buffer with a valid/ready handshake, and a free-running slot counter services the channels in fixed round-robin order.

## Interface
Parameters:
- DATA_W, 1: width of each channel word (bench uses 8).
- NUM_CH, 4: number of channels; legal range 2..16.
- CNT_W, 8: width of the frame counter.
- SEL_W, $clog2(NUM_CH): derived; not to be overridden.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  slot counter advance enable.
- ch_data  in  NUM_CH*DATA_W  channel words; channel i at bits [i*DATA_W +: DATA_W].
- ch_valid  in  NUM_CH  per-channel word valid.
- ch_ready  out  NUM_CH  per-channel buffer empty.
- data_out  out  DATA_W  multiplexed word, registered.
- sel_out  out  SEL_W  channel index of current slot, registered.
- out_valid  out  1  data_out carries a real word this cycle.
- frame_start  out  1  pulse, current slot is slot 0.
- underrun  out  1  pulse, current slot's buffer was empty.
- frame_cnt  out  CNT_W  completed-frame counter, wraps.

## Operation
- Per channel i: hold_vld[i], hold_data[i].
- `ch_ready[i] = !hold_vld[i] && !rst`.
- Accept on `ch_valid[i] && ch_ready[i]`: hold_data[i] <= word, hold_vld[i] <= 1.
- Slot counter `slot`, 0..NUM_CH-1. Increments when en=1 and wraps from NUM_CH-1 to 0. It holds when en=0.
- On each edge with en=1, service channel `slot`:
  - sel_out <= slot.
  - frame_start <= (slot==0).
  - If hold_vld[slot]=1: data_out <= hold_data[slot], out_valid <= 1, underrun <= 0, hold_vld[slot] <= 0.
  - Otherwise: data_out <= 0, out_valid <= 0, underrun <= 1.
- On each edge with en=0: out_valid, frame_start and underrun <= 0, data_out <= 0, sel_out holds. Buffers keep accepting.
- frame_cnt increments on every edge where en=1 and slot==NUM_CH-1. It wraps from 2^CNT_W-1 to 0.
- A consume and an accept cannot hit the same channel on the same edge, because ready is low while the buffer is full. The refilled word is visible from the next edge, which leaves NUM_CH-1 cycles to refill before the next slot i.
- Accepts on other channels proceed in the same edge as a consume on channel slot.

## Timing
- Reset (asynchronous assert; release is synchronous to clk):
  - Registers: slot=0, hold_vld=0, hold_data=0.
  - Outputs: data_out=0, sel_out=0, out_valid=0, frame_start=0, underrun=0, frame_cnt=0.
  - ch_ready=0 while rst=1.
- Reset asserted mid-frame drops all buffered words with no output. The first slot after release is slot 0.
- Output latency: 1 cycle from the servicing edge (all outputs registered). Worst-case buffer-to-output latency is NUM_CH cycles with en held high.
- With en held high from reset release, the first edge emits slot 0 with frame_start=1. Slots follow 0,1,..,NUM_CH-1,0,...
- ch_valid must hold its word stable until the edge where ch_valid&&ch_ready is seen.

## Structure
- Package tdm_mux_pkg:
  - default NUM_CH and DATA_W constants;
  - a SEL_W width function;
  - the slot index typedef.
- Sub-module tdm_chan_buffer: one-entry holding register with valid/ready in, and consume strobe and data/valid out. It is instantiated NUM_CH times.
- The top level holds the slot counter, output register and frame counter.

## Test plan
- Reset: assert rst mid-run with 2 words buffered. Outputs, frame_cnt and ch_ready go 0 immediately. After release the first emitted slot is 0 and no stale word appears.
- Full round-robin (DATA_W=8): preload ch0..3 = 0x11, 0x22, 0x33, 0x44 with en=0, then raise en. Over the next 4 edges: sel_out 0,1,2,3; data_out 0x11..0x44; out_valid=1; frame_start only on the first; frame_cnt 0→1.
- Underrun: only ch2 loaded (0xA5). The frame gives underrun=1 and out_valid=0 on slots 0, 1, 3. Slot 2 gives data_out=0xA5 and out_valid=1.
- Backpressure: hold ch1_valid high with a new word every cycle. ch_ready[1] drops after accept and rises one cycle after slot 1 consumes. Exactly one word is emitted per frame, with no loss or duplication.
- en gating: drop en at slot 2 for 5 cycles. sel_out stays at 1 (last serviced); out_valid, frame_start and underrun stay 0. Resuming services slot 2 next.
- Wrap: CNT_W=8, run 256 frames. frame_cnt goes 255→0 at the end of frame 256, and the slot wraps 3→0 every frame.

Source files
------------

// File: rtl/tdm_mux_pkg.sv
// Shared constants, helpers and types for the TDM signal multiplexer.
package tdm_mux_pkg;

    localparam int DEFAULT_NUM_CH = 4;
    localparam int DEFAULT_DATA_W = 1;

    // A one-channel configuration still needs a 1-bit select.
    function automatic int sel_width(input int num_ch);
        return (num_ch <= 1) ? 1 : $clog2(num_ch);
    endfunction

    typedef logic [sel_width(DEFAULT_NUM_CH)-1:0] slot_idx_t;

endpackage

// File: rtl/tdm_chan_buffer.sv
// One-entry holding register for a single TDM channel.
// A word is accepted only while empty; consume empties it.
module tdm_chan_buffer #(
    parameter int DATA_W = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
);

    logic [DATA_W-1:0] hold_data_reg;
    logic              hold_vld_reg;

    // Ready is forced low during reset so that no producer sees a handshake.
    assign wr_ready = !hold_vld_reg && !rst;
    assign rd_data  = hold_data_reg;
    assign rd_valid = hold_vld_reg;

    // rd_en is only raised while full and an accept needs empty, so the two never coincide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_data_reg <= '0;
            hold_vld_reg  <= 1'b0;
        end else if (rd_en) begin
            hold_vld_reg  <= 1'b0;
        end else if (wr_valid && wr_ready) begin
            hold_data_reg <= wr_data;
            hold_vld_reg  <= 1'b1;
        end
    end

endmodule

// File: rtl/tdm_signal_multiplexer.sv
// Round-robin TDM multiplexer: NUM_CH buffered channels merged into one
// slotted stream tagged with the channel index, plus a frame counter.
module tdm_signal_multiplexer
    import tdm_mux_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int NUM_CH = DEFAULT_NUM_CH,
    parameter int CNT_W  = 8,
    parameter int SEL_W  = sel_width(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic [NUM_CH-1:0]        ch_valid,
    output logic [NUM_CH-1:0]        ch_ready,
    output logic [DATA_W-1:0]        data_out,
    output logic [SEL_W-1:0]         sel_out,
    output logic                     out_valid,
    output logic                     frame_start,
    output logic                     underrun,
    output logic [CNT_W-1:0]         frame_cnt
);

    generate
        if (NUM_CH < 2 || NUM_CH > 16) begin : g_bad_num_ch
            $error("tdm_signal_multiplexer: NUM_CH must be in 2..16");
        end
    endgenerate

    logic [SEL_W-1:0]  slot_reg;
    logic [SEL_W-1:0]  slot_next;
    logic              last_slot;
    logic [NUM_CH-1:0] hold_vld;
    logic [NUM_CH-1:0] consume;
    logic [DATA_W-1:0] hold_data [NUM_CH];
    logic [DATA_W-1:0] slot_data;
    logic              slot_vld;

    assign last_slot = (slot_reg == SEL_W'(NUM_CH - 1));
    assign slot_next = last_slot ? '0 : slot_reg + 1'b1;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
            assign consume[gi] = en && (slot_reg == SEL_W'(gi)) && hold_vld[gi];

            tdm_chan_buffer #(
                .DATA_W (DATA_W)
            ) u_buf (
                .clk      (clk),
                .rst      (rst),
                .wr_data  (ch_data[gi*DATA_W +: DATA_W]),
                .wr_valid (ch_valid[gi]),
                .wr_ready (ch_ready[gi]),
                .rd_en    (consume[gi]),
                .rd_data  (hold_data[gi]),
                .rd_valid (hold_vld[gi])
            );
        end
    endgenerate

    // Explicit compare-based mux keeps the selection safe for non-power-of-two NUM_CH.
    always_comb begin
        slot_data = '0;
        slot_vld  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (slot_reg == SEL_W'(i)) begin
                slot_data = hold_data[i];
                slot_vld  = hold_vld[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_reg    <= '0;
            data_out    <= '0;
            sel_out     <= '0;
            out_valid   <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            frame_cnt   <= '0;
        end else if (en) begin
            slot_reg    <= slot_next;
            sel_out     <= slot_reg;
            frame_start <= (slot_reg == '0);
            out_valid   <= slot_vld;
            underrun    <= !slot_vld;
            data_out    <= slot_vld ? slot_data : '0;
            if (last_slot) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end else begin
            // sel_out keeps the last serviced slot while the stream is paused.
            data_out    <= '0;
            out_valid   <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end
    end

endmodule
